mcb_ini_seq: RTL and testbench
==============================

MCB_INI_SEQ -- requirements
Module: mcb_ini_seq

Interface
REQ-001 The module SHALL have these parameters (name, default, meaning):
- RANKS, 1: chip selects initialised in turn, legal range 1..4.
- CtINIw, 20000: power-up wait length in cycles minus 1.
- IrefN, 2: auto-refresh commands per rank, minimum 1.
- CtRP, 2: cycles after PREA minus 1.
- CtRFC, 6: cycles after REF minus 1.
- CtMRD, 1: cycles after LMR or EMR minus 1.
- EMR_EN, 0: when 1, issue EMR before LMR.
- AUTO_START, 1: when 1, start the sequence from reset release.
REQ-002 The module SHALL have these ports (name, direction, width, meaning):
- mcb_clk, in, 1: clock.
- mcb_rst_n, in, 1: reset.
- mcb_sclr_n, in, 1: synchronous clear, active-low.
- i_start, in, 1: re-initialisation request.
- i_prea, out, 1: precharge-all strobe.
- i_ref, out, 1: auto-refresh strobe.
- i_emr, out, 1: extended mode register load strobe.
- i_lmr, out, 1: mode register load strobe.
- i_cs, out, RANKS: one-hot target rank, valid while any strobe is high.
- i_busy, out, 1: sequence in progress.
- i_ready, out, 1: initialisation complete.
REQ-003 The module SHALL use one clock, mcb_clk; reset mcb_rst_n SHALL be asynchronous and active-low.

Function
REQ-004 The FSM SHALL have exactly these states: IDLE, WAIT, PREA, REF, EMR, LMR, GAP, DONE.
REQ-005 Every strobe SHALL be registered and high for exactly one cycle; no two strobes SHALL be high in the same cycle.
REQ-006 WAIT: a counter of width clog2(CtINIw+1) SHALL count from 0; when it equals CtINIw, the next state SHALL be PREA.
REQ-007 GAP: after a strobe for command X at cycle t, the next strobe SHALL occur at cycle t+Ct(X)+1, where Ct(PREA)=CtRP, Ct(REF)=CtRFC, Ct(EMR)=Ct(LMR)=CtMRD.
REQ-008 Per-rank order SHALL be: PREA, then IrefN x REF, then EMR (only if EMR_EN=1), then LMR.
REQ-009 The refresh counter SHALL be cleared on every PREA.
REQ-010 Rank index SHALL start at 0 and increment after each rank's LMR gap.
REQ-011 After the final rank's LMR gap, the FSM SHALL enter DONE with i_ready=1 and i_busy=0.
REQ-012 With AUTO_START=1, the FSM SHALL enter WAIT on the first cycle after reset release.
REQ-013 With AUTO_START=0, the FSM SHALL remain in IDLE until i_start=1, then enter WAIT.
REQ-014 i_start in DONE SHALL drop i_ready on the next cycle and enter PREA for rank 0, skipping WAIT.
REQ-015 i_start in any other state SHALL be ignored.
REQ-016 i_busy SHALL be 1 in every state except IDLE and DONE.
REQ-017 mcb_sclr_n=0 SHALL take priority over i_start.
REQ-018 mcb_sclr_n=0 SHALL clear all counters and strobes, force i_ready=0, and move the FSM to IDLE (AUTO_START=0) or WAIT (AUTO_START=1) on the next edge.
REQ-019 A clear mid-sequence SHALL restart from the power-up wait; no partial rank state SHALL be retained.
REQ-020 i_cs SHALL be 0 whenever no strobe is high.

Reset
REQ-021 On mcb_rst_n=0 the FSM SHALL go to IDLE immediately.
REQ-022 On mcb_rst_n=0 all counters SHALL be 0 and the rank index SHALL be 0.
REQ-023 On mcb_rst_n=0 i_prea, i_ref, i_emr, i_lmr, i_cs, i_busy and i_ready SHALL all be 0.
REQ-024 Reset assertion mid-sequence SHALL abort the sequence with no further strobes.

Structure
REQ-025 The timing parameters and their default values SHALL live in the shared MCB parameter include, alongside the existing initialisation constants.
REQ-026 The state encoding SHALL live in the same include.
REQ-027 A single sub-module, mcb_ini_gap_cnt, SHALL be used for the loadable down-counter that implements the per-command gaps.
REQ-028 All counter widths SHALL be derived with clog2 from the parameters; counters SHALL never wrap.

Verification
REQ-029 The bench SHALL cover these scenarios, all with CtINIw=9, IrefN=2, CtRP=2, CtRFC=6, CtMRD=1, RANKS=2, EMR_EN=1 unless stated:
- Release reset -> first i_prea at edge 10 (T); i_ref at T+3 and T+10; i_emr at T+17; i_lmr at T+19; each with i_cs=01.
- Same run -> rank 1 sequence starts at T+21 with i_cs=10; i_lmr at T+40; i_ready=1 from T+42.
- In DONE, pulse i_start -> i_ready=0 next cycle; i_prea on the following cycle; full two-rank sequence repeats with no power-up wait.
- Assert mcb_sclr_n during the second REF gap -> no strobes during the clear; i_ready=0; sequence restarts with i_prea 10 edges after release.
- EMR_EN=0, IrefN=1, RANKS=1 -> order is PREA, REF, LMR at T, T+3, T+10; i_ready at T+12.
- AUTO_START=0 -> all outputs 0 for 50 cycles; i_start -> first i_prea 10 edges later; i_start during busy -> no effect on strobe timing.

Source files
------------

// File: rtl/mcb_ini_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mcb_ini_seq_pkg
//  Purpose  : Shared MCB parameter include. Holds the default initialisation
//             timing constants, the init-sequencer state encoding and the
//             counter-width helpers.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package mcb_ini_seq_pkg;

  // Initialisation constants (defaults for the sequencer parameters)
  localparam int MCB_RANKS_MAX      = 4;
  localparam int MCB_RANKS_DEF      = 1;
  localparam int MCB_CT_INIW_DEF    = 20000;
  localparam int MCB_IREF_N_DEF     = 2;
  localparam int MCB_CT_RP_DEF      = 2;
  localparam int MCB_CT_RFC_DEF     = 6;
  localparam int MCB_CT_MRD_DEF     = 1;
  localparam int MCB_EMR_EN_DEF     = 0;
  localparam int MCB_AUTO_START_DEF = 1;

  // Init-sequencer state encoding
  localparam int                  MCB_ST_W    = 3;
  localparam logic [MCB_ST_W-1:0] MCB_ST_IDLE = 3'd0;
  localparam logic [MCB_ST_W-1:0] MCB_ST_WAIT = 3'd1;
  localparam logic [MCB_ST_W-1:0] MCB_ST_PREA = 3'd2;
  localparam logic [MCB_ST_W-1:0] MCB_ST_REF  = 3'd3;
  localparam logic [MCB_ST_W-1:0] MCB_ST_EMR  = 3'd4;
  localparam logic [MCB_ST_W-1:0] MCB_ST_LMR  = 3'd5;
  localparam logic [MCB_ST_W-1:0] MCB_ST_GAP  = 3'd6;
  localparam logic [MCB_ST_W-1:0] MCB_ST_DONE = 3'd7;

  // Bits needed to hold the values 0..n-1 (never less than one bit)
  function automatic int mcb_cw(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int mcb_max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mcb_ini_seq_gap.sv
`default_nettype none
// ============================================================================
//  Module   : mcb_ini_gap_cnt
//  Purpose  : Loadable down-counter timing the idle gap after each command.
//             Load with (gap cycles - 1); o_zero flags the last gap cycle.
//  Ports    : mcb_clk     - clock
//             mcb_rst_n   - asynchronous active-low reset
//             i_clr       - synchronous clear to zero
//             i_load      - load i_load_val
//             i_load_val  - reload value
//             o_zero      - counter is zero
//  Revision : 1.0  initial release
// ============================================================================
module mcb_ini_gap_cnt #(
  parameter int W = 3
) (
  input  logic         mcb_clk,
  input  logic         mcb_rst_n,
  input  logic         i_clr,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  // Saturates at zero so it can never wrap
  always_ff @(posedge mcb_clk or negedge mcb_rst_n) begin
    if (!mcb_rst_n)          r_cnt <= '0;
    else if (i_clr)          r_cnt <= '0;
    else if (i_load)         r_cnt <= i_load_val;
    else if (r_cnt != '0)    r_cnt <= r_cnt - 1'b1;
  end

  assign o_zero = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/mcb_ini_seq.sv
`default_nettype none
// ============================================================================
//  Module   : mcb_ini_seq
//  Purpose  : SDRAM power-up initialisation sequencer. After a power-up wait,
//             issues per rank: PREA, IrefN x REF, optional EMR, LMR, with a
//             programmable gap after each command, then reports ready.
//  Ports    : mcb_clk     - clock
//             mcb_rst_n   - asynchronous active-low reset
//             mcb_sclr_n  - synchronous clear, active-low
//             i_start     - re-initialisation request (honoured in IDLE/DONE)
//             i_prea/i_ref/i_emr/i_lmr - one-cycle command strobes
//             i_cs        - one-hot target rank, zero when no strobe
//             i_busy      - sequence in progress
//             i_ready     - initialisation complete
//  Revision : 1.0  initial release
// ============================================================================
module mcb_ini_seq
  import mcb_ini_seq_pkg::*;
#(
  parameter int RANKS      = MCB_RANKS_DEF,
  parameter int CtINIw     = MCB_CT_INIW_DEF,
  parameter int IrefN      = MCB_IREF_N_DEF,
  parameter int CtRP       = MCB_CT_RP_DEF,
  parameter int CtRFC      = MCB_CT_RFC_DEF,
  parameter int CtMRD      = MCB_CT_MRD_DEF,
  parameter int EMR_EN     = MCB_EMR_EN_DEF,
  parameter int AUTO_START = MCB_AUTO_START_DEF
) (
  input  logic             mcb_clk,
  input  logic             mcb_rst_n,
  input  logic             mcb_sclr_n,
  input  logic             i_start,
  output logic             i_prea,
  output logic             i_ref,
  output logic             i_emr,
  output logic             i_lmr,
  output logic [RANKS-1:0] i_cs,
  output logic             i_busy,
  output logic             i_ready
);

  localparam int c_WW = mcb_cw(CtINIw + 1);
  localparam int c_FW = mcb_cw(IrefN + 1);
  localparam int c_RW = mcb_cw(RANKS);
  localparam int c_GW = mcb_cw(mcb_max3(CtRP, CtRFC, CtMRD) + 1);

  localparam logic [c_WW-1:0]  c_INI_LAST  = c_WW'(CtINIw);
  localparam logic [c_FW-1:0]  c_REF_LAST  = c_FW'(IrefN - 1);
  localparam logic [c_RW-1:0]  c_RANK_LAST = c_RW'(RANKS - 1);
  // Gap counter reload = Ct - 1; a zero Ct skips the GAP state entirely
  localparam logic [c_GW-1:0]  c_GAP_RP    = c_GW'((CtRP  > 0) ? CtRP  - 1 : 0);
  localparam logic [c_GW-1:0]  c_GAP_RFC   = c_GW'((CtRFC > 0) ? CtRFC - 1 : 0);
  localparam logic [c_GW-1:0]  c_GAP_MRD   = c_GW'((CtMRD > 0) ? CtMRD - 1 : 0);
  localparam logic [RANKS-1:0] c_CS_ONE    = RANKS'(1);

  logic [MCB_ST_W-1:0] r_state, w_state_nxt;
  logic [MCB_ST_W-1:0] r_pend, w_pend_nxt;     // command to issue when GAP ends
  logic [MCB_ST_W-1:0] w_follow;               // command after the current one
  logic [c_WW-1:0]     r_wcnt, w_wcnt_nxt;
  logic [c_FW-1:0]     r_ref_cnt, w_ref_nxt;
  logic [c_RW-1:0]     r_rank, w_rank_nxt;
  logic [c_GW-1:0]     w_ct, w_gap_val;
  logic                w_ct_none, w_gap_load, w_gap_clr, w_gap_zero;
  logic                w_prea, w_ref, w_emr, w_lmr, w_busy, w_ready;
  logic [RANKS-1:0]    w_cs;
  logic                r_prea, r_ref, r_emr, r_lmr, r_busy, r_ready;
  logic [RANKS-1:0]    r_cs;

  mcb_ini_gap_cnt #(
    .W (c_GW)
  ) u_gap (
    .mcb_clk    (mcb_clk),
    .mcb_rst_n  (mcb_rst_n),
    .i_clr      (w_gap_clr),
    .i_load     (w_gap_load),
    .i_load_val (w_gap_val),
    .o_zero     (w_gap_zero)
  );

  // State register and sequence counters
  always_ff @(posedge mcb_clk or negedge mcb_rst_n) begin
    if (!mcb_rst_n) begin
      r_state   <= MCB_ST_IDLE;
      r_pend    <= MCB_ST_IDLE;
      r_wcnt    <= '0;
      r_ref_cnt <= '0;
      r_rank    <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_pend    <= w_pend_nxt;
      r_wcnt    <= w_wcnt_nxt;
      r_ref_cnt <= w_ref_nxt;
      r_rank    <= w_rank_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    w_pend_nxt  = r_pend;
    w_wcnt_nxt  = '0;
    w_ref_nxt   = r_ref_cnt;
    w_rank_nxt  = r_rank;
    w_gap_load  = 1'b0;
    w_gap_val   = '0;
    w_gap_clr   = 1'b0;
    w_follow    = MCB_ST_IDLE;
    w_ct        = '0;
    w_ct_none   = 1'b0;

    // Successor command and its gap, for the four command states
    case (r_state)
      MCB_ST_PREA: begin
        w_follow  = MCB_ST_REF;
        w_ct      = c_GAP_RP;
        w_ct_none = (CtRP == 0);
      end
      MCB_ST_REF: begin
        if (r_ref_cnt == c_REF_LAST)
          w_follow = (EMR_EN != 0) ? MCB_ST_EMR : MCB_ST_LMR;
        else
          w_follow = MCB_ST_REF;
        w_ct      = c_GAP_RFC;
        w_ct_none = (CtRFC == 0);
      end
      MCB_ST_EMR: begin
        w_follow  = MCB_ST_LMR;
        w_ct      = c_GAP_MRD;
        w_ct_none = (CtMRD == 0);
      end
      MCB_ST_LMR: begin
        w_follow  = (r_rank == c_RANK_LAST) ? MCB_ST_DONE : MCB_ST_PREA;
        w_ct      = c_GAP_MRD;
        w_ct_none = (CtMRD == 0);
      end
      default: ;
    endcase

    case (r_state)
      MCB_ST_IDLE: begin
        if ((AUTO_START != 0) || i_start) w_state_nxt = MCB_ST_WAIT;
      end
      MCB_ST_WAIT: begin
        if (r_wcnt == c_INI_LAST) w_state_nxt = MCB_ST_PREA;
        else                      w_wcnt_nxt  = r_wcnt + 1'b1;
      end
      MCB_ST_PREA, MCB_ST_REF, MCB_ST_EMR, MCB_ST_LMR: begin
        if (w_ct_none) begin
          w_state_nxt = w_follow;
        end else begin
          w_state_nxt = MCB_ST_GAP;
          w_pend_nxt  = w_follow;
          w_gap_load  = 1'b1;
          w_gap_val   = w_ct;
        end
        if (r_state == MCB_ST_PREA) w_ref_nxt = '0;
        if (r_state == MCB_ST_REF)  w_ref_nxt = r_ref_cnt + 1'b1;
        if (r_state == MCB_ST_LMR && w_follow == MCB_ST_PREA)
          w_rank_nxt = r_rank + 1'b1;
      end
      MCB_ST_GAP: begin
        if (w_gap_zero) w_state_nxt = r_pend;
      end
      MCB_ST_DONE: begin
        // One idle GAP cycle drops ready before the rank-0 PREA strobe
        if (i_start) begin
          w_state_nxt = MCB_ST_GAP;
          w_pend_nxt  = MCB_ST_PREA;
          w_gap_load  = 1'b1;
          w_gap_val   = '0;
          w_rank_nxt  = '0;
        end
      end
      default: w_state_nxt = MCB_ST_IDLE;
    endcase

    // Synchronous clear wins over everything, including i_start
    if (!mcb_sclr_n) begin
      w_state_nxt = (AUTO_START != 0) ? MCB_ST_WAIT : MCB_ST_IDLE;
      w_pend_nxt  = MCB_ST_IDLE;
      w_wcnt_nxt  = '0;
      w_ref_nxt   = '0;
      w_rank_nxt  = '0;
      w_gap_load  = 1'b0;
      w_gap_clr   = 1'b1;
    end
  end

  // Output decode from the next state so every output is a flop
  always_comb begin
    w_prea  = (w_state_nxt == MCB_ST_PREA);
    w_ref   = (w_state_nxt == MCB_ST_REF);
    w_emr   = (w_state_nxt == MCB_ST_EMR);
    w_lmr   = (w_state_nxt == MCB_ST_LMR);
    w_busy  = (w_state_nxt != MCB_ST_IDLE) && (w_state_nxt != MCB_ST_DONE);
    w_ready = (w_state_nxt == MCB_ST_DONE);
    w_cs    = '0;
    if (w_prea || w_ref || w_emr || w_lmr) w_cs = c_CS_ONE << w_rank_nxt;
  end

  always_ff @(posedge mcb_clk or negedge mcb_rst_n) begin
    if (!mcb_rst_n) begin
      r_prea  <= 1'b0;
      r_ref   <= 1'b0;
      r_emr   <= 1'b0;
      r_lmr   <= 1'b0;
      r_cs    <= '0;
      r_busy  <= 1'b0;
      r_ready <= 1'b0;
    end else begin
      r_prea  <= w_prea;
      r_ref   <= w_ref;
      r_emr   <= w_emr;
      r_lmr   <= w_lmr;
      r_cs    <= w_cs;
      r_busy  <= w_busy;
      r_ready <= w_ready;
    end
  end

  assign i_prea  = r_prea;
  assign i_ref   = r_ref;
  assign i_emr   = r_emr;
  assign i_lmr   = r_lmr;
  assign i_cs    = r_cs;
  assign i_busy  = r_busy;
  assign i_ready = r_ready;

endmodule
`default_nettype wire

// File: tb/tb_mcb_ini_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mcb_ini_seq
//  Purpose  : Directed self-checking bench for mcb_ini_seq. Three instances:
//             dut_a two ranks with EMR, dut_b one rank without EMR,
//             dut_c two ranks with AUTO_START=0.
//             Edge k=0 (T) is the edge that produces the first i_prea; the
//             first edge after reset release enters WAIT (k=-10).
//  Revision : 1.0  initial release
// ============================================================================
module tb_mcb_ini_seq;

  logic clk     = 1'b0;
  logic rst_n   = 1'b1;
  logic sclr_a  = 1'b1;
  logic sclr_b  = 1'b1;
  logic sclr_c  = 1'b1;
  logic start_a = 1'b0;
  logic start_b = 1'b0;
  logic start_c = 1'b0;

  logic       prea_a, ref_a, emr_a, lmr_a, busy_a, ready_a;
  logic [1:0] cs_a;
  logic       prea_b, ref_b, emr_b, lmr_b, busy_b, ready_b;
  logic [0:0] cs_b;
  logic       prea_c, ref_c, emr_c, lmr_c, busy_c, ready_c;
  logic [1:0] cs_c;

  // {prea, ref, emr, lmr, cs, busy, ready}
  logic [7:0] obs_a, obs_c;
  logic [6:0] obs_b;
  assign obs_a = {prea_a, ref_a, emr_a, lmr_a, cs_a, busy_a, ready_a};
  assign obs_b = {prea_b, ref_b, emr_b, lmr_b, cs_b, busy_b, ready_b};
  assign obs_c = {prea_c, ref_c, emr_c, lmr_c, cs_c, busy_c, ready_c};

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  mcb_ini_seq #(.RANKS(2), .CtINIw(9), .IrefN(2), .CtRP(2), .CtRFC(6),
                .CtMRD(1), .EMR_EN(1), .AUTO_START(1)) dut_a (
    .mcb_clk(clk), .mcb_rst_n(rst_n), .mcb_sclr_n(sclr_a), .i_start(start_a),
    .i_prea(prea_a), .i_ref(ref_a), .i_emr(emr_a), .i_lmr(lmr_a),
    .i_cs(cs_a), .i_busy(busy_a), .i_ready(ready_a));

  mcb_ini_seq #(.RANKS(1), .CtINIw(9), .IrefN(1), .CtRP(2), .CtRFC(6),
                .CtMRD(1), .EMR_EN(0), .AUTO_START(1)) dut_b (
    .mcb_clk(clk), .mcb_rst_n(rst_n), .mcb_sclr_n(sclr_b), .i_start(start_b),
    .i_prea(prea_b), .i_ref(ref_b), .i_emr(emr_b), .i_lmr(lmr_b),
    .i_cs(cs_b), .i_busy(busy_b), .i_ready(ready_b));

  mcb_ini_seq #(.RANKS(2), .CtINIw(9), .IrefN(2), .CtRP(2), .CtRFC(6),
                .CtMRD(1), .EMR_EN(1), .AUTO_START(0)) dut_c (
    .mcb_clk(clk), .mcb_rst_n(rst_n), .mcb_sclr_n(sclr_c), .i_start(start_c),
    .i_prea(prea_c), .i_ref(ref_c), .i_emr(emr_c), .i_lmr(lmr_c),
    .i_cs(cs_c), .i_busy(busy_c), .i_ready(ready_c));

  // Hand-derived two-rank schedule, k relative to T:
  // rank0 P@0 R@3 R@10 E@17 L@19; rank1 P@21 R@24 R@31 E@38 L@40; ready@42+
  function automatic logic [7:0] exp_two(input int k);
    logic [7:0] v;
    v = 8'b0000_00_1_0;
    if (k >= 42) v = 8'b0000_00_0_1;
    else begin
      case (k)
        0:       v = 8'b1000_01_1_0;
        3, 10:   v = 8'b0100_01_1_0;
        17:      v = 8'b0010_01_1_0;
        19:      v = 8'b0001_01_1_0;
        21:      v = 8'b1000_10_1_0;
        24, 31:  v = 8'b0100_10_1_0;
        38:      v = 8'b0010_10_1_0;
        40:      v = 8'b0001_10_1_0;
        default: ;
      endcase
    end
    return v;
  endfunction

  // One rank, no EMR, one REF: P@0 R@3 L@10, ready@12+
  function automatic logic [6:0] exp_one(input int k);
    logic [6:0] v;
    v = 7'b0000_0_1_0;
    if (k >= 12) v = 7'b0000_0_0_1;
    else begin
      case (k)
        0:       v = 7'b1000_1_1_0;
        3:       v = 7'b0100_1_1_0;
        10:      v = 7'b0001_1_1_0;
        default: ;
      endcase
    end
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    sclr_a  = 1'b1; sclr_b  = 1'b1; sclr_c  = 1'b1;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    repeat (2) step();
    n_checks++;
    if (obs_a !== 8'd0) $display("FAIL reset_a got=%b exp=%b", obs_a, 8'd0);
    else n_pass++;
    n_checks++;
    if (obs_b !== 7'd0) $display("FAIL reset_b got=%b exp=%b", obs_b, 7'd0);
    else n_pass++;
    n_checks++;
    if (obs_c !== 8'd0) $display("FAIL reset_c got=%b exp=%b", obs_c, 8'd0);
    else n_pass++;
  endtask

  task automatic test_two_rank();
    logic [7:0] e;
    do_reset();
    for (int k = -10; k <= 44; k++) begin
      step();
      e = exp_two(k);
      n_checks++;
      if (obs_a !== e) $display("FAIL two_rank k=%0d got=%b exp=%b", k, obs_a, e);
      else n_pass++;
    end
  endtask

  // Continues from DONE left by test_two_rank
  task automatic test_restart();
    logic [7:0] e;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    n_checks++;
    if (obs_a !== 8'b0000_00_1_0)
      $display("FAIL restart_ready_drop got=%b exp=%b", obs_a, 8'b0000_00_1_0);
    else n_pass++;
    for (int k = 0; k <= 44; k++) begin
      step();
      e = exp_two(k);
      n_checks++;
      if (obs_a !== e) $display("FAIL restart k=%0d got=%b exp=%b", k, obs_a, e);
      else n_pass++;
    end
  endtask

  task automatic test_sclr();
    logic [7:0] e;
    do_reset();
    for (int k = -10; k <= 11; k++) begin
      step();
      e = exp_two(k);
      n_checks++;
      if (obs_a !== e) $display("FAIL sclr_pre k=%0d got=%b exp=%b", k, obs_a, e);
      else n_pass++;
    end
    // Clear sampled on edges T+12..T+16, inside the second REF gap
    sclr_a = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      n_checks++;
      if (obs_a !== 8'b0000_00_1_0)
        $display("FAIL sclr_hold i=%0d got=%b exp=%b", i, obs_a, 8'b0000_00_1_0);
      else n_pass++;
    end
    sclr_a = 1'b1;
    for (int k = -9; k <= 44; k++) begin
      step();
      e = exp_two(k);
      n_checks++;
      if (obs_a !== e) $display("FAIL sclr_post k=%0d got=%b exp=%b", k, obs_a, e);
      else n_pass++;
    end
  endtask

  task automatic test_single_rank();
    logic [6:0] e;
    do_reset();
    for (int k = -10; k <= 14; k++) begin
      step();
      e = exp_one(k);
      n_checks++;
      if (obs_b !== e) $display("FAIL single_rank k=%0d got=%b exp=%b", k, obs_b, e);
      else n_pass++;
    end
  endtask

  task automatic test_auto_start_off();
    logic [7:0] e;
    do_reset();
    for (int i = 0; i < 50; i++) begin
      step();
      n_checks++;
      if (obs_c !== 8'd0) $display("FAIL idle_hold i=%0d got=%b exp=%b", i, obs_c, 8'd0);
      else n_pass++;
    end
    start_c = 1'b1;
    step();
    start_c = 1'b0;
    e = exp_two(-10);
    n_checks++;
    if (obs_c !== e) $display("FAIL start_wait got=%b exp=%b", obs_c, e);
    else n_pass++;
    for (int k = -9; k <= 44; k++) begin
      step();
      e = exp_two(k);
      n_checks++;
      if (obs_c !== e) $display("FAIL start_seq k=%0d got=%b exp=%b", k, obs_c, e);
      else n_pass++;
      // i_start while busy (in WAIT and in a REF gap) must be ignored
      start_c = (k == -5) || (k == 5);
    end
    start_c = 1'b0;
  endtask

  task automatic test_reset_abort();
    logic [7:0] e;
    do_reset();
    for (int k = -10; k <= 3; k++) begin
      step();
      e = exp_two(k);
      n_checks++;
      if (obs_a !== e) $display("FAIL abort_pre k=%0d got=%b exp=%b", k, obs_a, e);
      else n_pass++;
    end
    // REF strobe is high here; asynchronous reset must kill it at once
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (obs_a !== 8'd0) $display("FAIL abort_now got=%b exp=%b", obs_a, 8'd0);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (obs_a !== 8'd0) $display("FAIL abort_hold i=%0d got=%b exp=%b", i, obs_a, 8'd0);
      else n_pass++;
    end
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_two_rank();
    test_restart();
    test_sclr();
    test_single_rank();
    test_auto_start_off();
    test_reset_abort();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
